strassen_row_feeder_ctrl: RTL and testbench

STRASSEN_ROW_FEEDER_CTRL -- requirements
Module: strassen_row_feeder_ctrl

---
 rtl/strassen_row_feeder_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_strassen_row_feeder_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/strassen_row_feeder_ctrl.sv
// Row feeder for a Strassen multiply core: streams MAT_SIZE A/B rows in a
// 4-way interleaved order, then waits (with a watchdog) for the core to finish.
module strassen_row_feeder_ctrl #(
  parameter int unsigned MAT_SIZE       = 256,
  parameter int unsigned ELEM_BITWIDTH  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned ROW_WIDTH     = MAT_SIZE * ELEM_BITWIDTH,
  localparam int unsigned AW            = $clog2(MAT_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 rd_en_o,
  output logic [AW-1:0]        rd_addr_o,
  input  logic [ROW_WIDTH-1:0] rd_data_a_i,
  input  logic [ROW_WIDTH-1:0] rd_data_b_i,
  output logic [ROW_WIDTH-1:0] a_row_o,
  output logic [ROW_WIDTH-1:0] b_row_o,
  output logic                 row_valid_o,
  input  logic                 core_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_timeout_o,
  output logic                 err_early_o
);

  localparam int unsigned KW  = AW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_WAIT,
    S_FINISH
  } state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   fl_q, fl_d;
  logic                   rd_en_q, rd_en_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic                   cap_q, cap_d;
  logic                   row_valid_q, row_valid_d;
  logic [ROW_WIDTH-1:0]   a_row_q, a_row_d;
  logic [ROW_WIDTH-1:0]   b_row_q, b_row_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_t_q, err_t_d;
  logic                   err_e_q, err_e_d;
  logic [1:0]             rst_sync_q;

  // Release-side reset synchroniser; start is only honoured once it has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wd_d        = wd_q;
    fl_d        = fl_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    cap_d       = rd_en_q;
    row_valid_d = cap_q;
    a_row_d     = a_row_q;
    b_row_d     = b_row_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_t_d     = err_t_q;
    err_e_d     = err_e_q;

    // Capture the row returned for the read issued two cycles back.
    if (cap_q) begin
      a_row_d = rd_data_a_i;
      b_row_d = rd_data_b_i;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i && rst_sync_q[1]) begin
          state_d   = S_FEED;
          k_d       = '0;
          wd_d      = '0;
          err_t_d   = 1'b0;
          err_e_d   = 1'b0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      S_FEED: begin
        if (core_done_i) err_e_d = 1'b1;
        if (k_q == KW'(MAT_SIZE - 1)) begin
          state_d = S_FLUSH;
          fl_d    = 1'b0;
        end else begin
          k_d       = k_q + KW'(1);
          rd_en_d   = 1'b1;
          // Group-major order: k[1:0] selects the quarter, k[AW-1:2] the row in it.
          rd_addr_d = {k_d[1:0], k_d[AW-1:2]};
        end
      end
      S_FLUSH: begin
        if (core_done_i) err_e_d = 1'b1;
        if (fl_q) state_d = S_WAIT;
        else      fl_d    = 1'b1;
      end
      S_WAIT: begin
        if (core_done_i) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          err_t_d = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything: drop in-flight rows, keep error history.
    if (abort_i) begin
      state_d     = S_IDLE;
      rd_en_d     = 1'b0;
      cap_d       = 1'b0;
      row_valid_d = 1'b0;
      a_row_d     = a_row_q;
      b_row_d     = b_row_q;
      done_d      = 1'b0;
      err_t_d     = err_t_q;
      err_e_d     = err_e_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      wd_q        <= '0;
      fl_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      cap_q       <= 1'b0;
      row_valid_q <= 1'b0;
      a_row_q     <= '0;
      b_row_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_t_q     <= 1'b0;
      err_e_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wd_q        <= wd_d;
      fl_q        <= fl_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      cap_q       <= cap_d;
      row_valid_q <= row_valid_d;
      a_row_q     <= a_row_d;
      b_row_q     <= b_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_t_q     <= err_t_d;
      err_e_q     <= err_e_d;
    end
  end

  assign rd_en_o       = rd_en_q;
  assign rd_addr_o     = rd_addr_q;
  assign a_row_o       = a_row_q;
  assign b_row_o       = b_row_q;
  assign row_valid_o   = row_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_t_q;
  assign err_early_o   = err_e_q;

endmodule

// File: tb/tb_strassen_row_feeder_ctrl.sv
// Scoreboard bench for strassen_row_feeder_ctrl: a transaction-level model
// predicts reads, rows, done pulses and flags; a negedge monitor checks them.
module tb_strassen_row_feeder_ctrl;

  localparam int unsigned M  = 8;
  localparam int unsigned EW = 8;
  localparam int unsigned T  = 20;
  localparam int unsigned RW = M * EW;
  localparam int unsigned AW = $clog2(M);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, abort_i, core_done_i;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [RW-1:0] rd_data_a_i, rd_data_b_i;
  logic [RW-1:0] a_row_o, b_row_o;
  logic          row_valid_o, busy_o, done_o, err_timeout_o, err_early_o;

  strassen_row_feeder_ctrl #(
    .MAT_SIZE      (M),
    .ELEM_BITWIDTH (EW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_a_i  (rd_data_a_i),
    .rd_data_b_i  (rd_data_b_i),
    .a_row_o      (a_row_o),
    .b_row_o      (b_row_o),
    .row_valid_o  (row_valid_o),
    .core_done_i  (core_done_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_timeout_o(err_timeout_o),
    .err_early_o  (err_early_o)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int cyc; } rd_ev_t;
  typedef struct { logic [RW-1:0] a; logic [RW-1:0] b; int cyc; } row_ev_t;

  rd_ev_t        rd_q[$];
  row_ev_t       row_q[$];
  int            done_q[$];
  logic [RW-1:0] mem_a [M];
  logic [RW-1:0] mem_b [M];
  logic [RW-1:0] last_a, last_b;
  rd_ev_t        me;
  row_ev_t       mr;
  int            md;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            blo, bhi;
  bit            mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  // Row memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_data_a_i <= mem_a[rd_addr_o];
      rd_data_b_i <= mem_b[rd_addr_o];
    end
  end

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk(busy_o == (cyc >= blo && cyc <= bhi), "busy", 64'(busy_o), 64'(cyc));
      if (rd_en_o) begin
        if (rd_q.size() == 0) chk(1'b0, "rd_en_unexpected", 64'(cyc), 64'(0));
        else begin
          me = rd_q.pop_front();
          chk(rd_addr_o == AW'(me.addr) && cyc == me.cyc, "rd_addr",
              {32'(cyc), 32'(rd_addr_o)}, {32'(me.cyc), 32'(me.addr)});
        end
      end
      if (row_valid_o) begin
        if (row_q.size() == 0) chk(1'b0, "row_unexpected", 64'(cyc), 64'(0));
        else begin
          mr = row_q.pop_front();
          chk(a_row_o == mr.a, "a_row", a_row_o, mr.a);
          chk(b_row_o == mr.b, "b_row", b_row_o, mr.b);
          chk(cyc == mr.cyc, "row_cycle", 64'(cyc), 64'(mr.cyc));
          last_a = mr.a;
          last_b = mr.b;
        end
      end else begin
        chk(a_row_o == last_a && b_row_o == last_b, "row_hold", a_row_o, last_a);
      end
      if (done_o) begin
        if (done_q.size() == 0) chk(1'b0, "done_unexpected", 64'(cyc), 64'(0));
        else begin
          md = done_q.pop_front();
          chk(cyc == md, "done_cycle", 64'(cyc), 64'(md));
        end
      end
    end
  end

  // One multiply: offsets (t) are cycles after FEED entry; -1 disables an event.
  task automatic run_txn(input int d, input int early_k, input int abort_k, input int sb_k);
    int n, last, tend, a_abs;
    bit exp_et, exp_ee;
    @(negedge clk);
    for (int i = 0; i < M; i++) begin
      mem_a[i] = {$urandom, $urandom};
      mem_b[i] = {$urandom, $urandom};
    end
    n     = cyc + 1;
    a_abs = (abort_k >= 0) ? n + abort_k : 32'h3fff_ffff;
    for (int j = 0; j < M; j++) begin
      int addr;
      addr = (j % 4) * (M / 4) + j / 4;
      if (n + j <= a_abs)     rd_q.push_back('{addr, n + j});
      if (n + j + 2 <= a_abs) row_q.push_back('{mem_a[addr], mem_b[addr], n + j + 2});
    end
    if (abort_k >= 0) begin
      last   = a_abs;
      exp_et = 1'b0;
      exp_ee = (early_k >= 0 && early_k < abort_k);
    end else if (d < T) begin
      last   = n + M + 2 + d + 1;
      done_q.push_back(last);
      exp_et = 1'b0;
      exp_ee = (early_k >= 0);
    end else begin
      last   = n + M + 2 + T - 1;
      exp_et = 1'b1;
      exp_ee = (early_k >= 0);
    end
    blo     = n;
    bhi     = last;
    start_i = 1'b1;
    tend    = last - n + 3;
    if (M + 3 + d > tend) tend = M + 3 + d;
    for (int t = 0; t <= tend; t++) begin
      @(negedge clk);
      start_i     = (t == sb_k);
      core_done_i = (t == early_k) || (t == M + 2 + d);
      abort_i     = (t == abort_k);
      if (t == 0) begin
        chk(err_timeout_o == 1'b0, "err_timeout_cleared", 64'(err_timeout_o), 64'(0));
        chk(err_early_o == 1'b0, "err_early_cleared", 64'(err_early_o), 64'(0));
      end
    end
    start_i     = 1'b0;
    core_done_i = 1'b0;
    abort_i     = 1'b0;
    chk(busy_o == 1'b0, "busy_end", 64'(busy_o), 64'(0));
    chk(err_timeout_o == exp_et, "err_timeout", 64'(err_timeout_o), 64'(exp_et));
    chk(err_early_o == exp_ee, "err_early", 64'(err_early_o), 64'(exp_ee));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    core_done_i = 1'b0;
    mon_en      = 1'b0;
    last_a      = '0;
    last_b      = '0;
    blo         = 1;
    bhi         = 0;
    #1;
    chk({rd_en_o, row_valid_o, done_o, busy_o, err_timeout_o, err_early_o} == 6'b0,
        "reset_ctrl", 64'({rd_en_o, row_valid_o, done_o, busy_o, err_timeout_o, err_early_o}), 64'(0));
    chk(rd_addr_o == '0 && a_row_o == '0 && b_row_o == '0, "reset_data", a_row_o, 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    run_txn(5, -1, -1, -1);   // plain run, interleaved order 0,2,4,6,1,3,5,7
    run_txn(25, -1, -1, -1);  // watchdog expiry
    run_txn(19, -1, -1, -1);  // core_done on the expiry cycle wins
    run_txn(20, -1, -1, -1);  // core_done one cycle too late
    run_txn(4, 3, -1, -1);    // early core_done in FEED
    run_txn(3, 9, -1, 12);    // early core_done in FLUSH, start in WAIT_DONE
    run_txn(6, -1, -1, 2);    // start while feeding
    run_txn(6, -1, 5, -1);    // abort mid-feed
    run_txn(6, 2, 0, -1);     // abort on first FEED cycle

    repeat (30) begin
      int d, ek, ak, sk, lastoff;
      d       = int'($urandom_range(0, 26));
      ek      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, M + 1)) : -1;
      ak      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, M - 1)) : -1;
      lastoff = (ak >= 0) ? ak : ((d < int'(T)) ? int'(M) + 3 + d : int'(M + 1 + T));
      sk      = ($urandom_range(0, 2) == 0 && lastoff >= 1) ? int'($urandom_range(1, lastoff)) : -1;
      run_txn(d, ek, ak, sk);
    end

    // Reset in the middle of FEED: outputs clear at once and nothing resumes.
    mon_en = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk(rd_en_o == 1'b1, "feeding_before_reset", 64'(rd_en_o), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({rd_en_o, row_valid_o, done_o, busy_o, err_timeout_o, err_early_o} == 6'b0,
        "midfeed_reset_ctrl", 64'({rd_en_o, row_valid_o, done_o, busy_o, err_timeout_o, err_early_o}), 64'(0));
    chk(rd_addr_o == '0 && a_row_o == '0 && b_row_o == '0, "midfeed_reset_data", a_row_o, 64'(0));
    last_a = '0;
    last_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk(busy_o == 1'b0 && rd_en_o == 1'b0, "no_resume", 64'({busy_o, rd_en_o}), 64'(0));
    blo    = 1;
    bhi    = 0;
    mon_en = 1'b1;
    run_txn(7, -1, -1, -1);

    repeat (4) @(negedge clk);
    chk(rd_q.size() == 0, "rd_queue_drained", 64'(rd_q.size()), 64'(0));
    chk(row_q.size() == 0, "row_queue_drained", 64'(row_q.size()), 64'(0));
    chk(done_q.size() == 0, "done_queue_drained", 64'(done_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
